// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, T-step indices, sequencer state and control-word types.
//   Used by ring_counter and controller_sequencer.
package cpu_pkg;
   localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                          OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JZ  = 4'h7,
                          OP_JC  = 4'h8, OP_MVB = 4'h9, OP_MVC = 4'hA, OP_OUT = 4'hB,
                          OP_HLT = 4'hF;
   localparam int T0 = 0, T1 = 1, T2 = 2, T3 = 3, T4 = 4;
   localparam int T_STATE_W = 10;
   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} state_e;
   typedef struct packed {
      logic count_pc;
      logic clear_pc;
      logic enable_pc;
      logic load_pc;
      logic load_accum;
      logic enable_accum;
      logic load_mar;
      logic ce_ram;
      logic we_ram;
      logic sub_mode;
      logic enable_alu;
      logic load_mdr_reg;
      logic enable_mdr_reg;
      logic load_b_reg;
      logic enable_b_reg;
      logic load_c_reg;
      logic enable_c_reg;
      logic load_temp_reg;
      logic load_output_reg;
      logic load_inst_reg;
      logic enable_inst_reg;
      logic clear_inst_reg;
   } ctrl_t;
   function automatic logic has_t3(input logic [3:0] op);
      return op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA};
   endfunction
   function automatic logic has_t4(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB};
   endfunction
endpackage

// File: rtl/ring_counter.sv
// ring_counter: one-hot T-step counter.
//   clk, clear (sync active-low reset), zero (clear to all-zero),
//   restart (load T0), step (rotate one position), t_state (one-hot out).
//   Priority: clear > zero > restart > step.
module ring_counter
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 zero,
   input  logic                 restart,
   input  logic                 step,
   output logic [T_STATE_W-1:0] t_state
);
   logic [T_STATE_W-1:0] t_state_q, t_state_d;
   always_comb
      t_state_d = zero ? '0 :
                  restart ? T_STATE_W'(1) :
                  step ? {t_state_q[T_STATE_W-2:0], t_state_q[T_STATE_W-1]} : t_state_q;
   always_ff @(posedge clk)
      t_state_q <= !clear ? '0 : t_state_d;
   assign t_state = t_state_q;
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: INIT/RUN/HALT instruction sequencer with Moore-decoded controls.
//   clk, clear (sync active-low), enable_ring_counter (advance / freeze),
//   controller_sequencer_input (IR, opcode [7:4]), zero_flag, carry_flag,
//   22 single-bit control outputs, t_state (one-hot step), halted.
module controller_sequencer
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 enable_ring_counter,
   input  logic [7:0]           controller_sequencer_input,
   input  logic                 zero_flag,
   input  logic                 carry_flag,
   output logic                 count_pc,
   output logic                 clear_pc,
   output logic                 enable_pc,
   output logic                 load_pc,
   output logic                 load_accum,
   output logic                 enable_accum,
   output logic                 load_mar,
   output logic                 ce_ram,
   output logic                 we_ram,
   output logic                 sub_mode,
   output logic                 enable_alu,
   output logic                 load_mdr_reg,
   output logic                 enable_mdr_reg,
   output logic                 load_b_reg,
   output logic                 enable_b_reg,
   output logic                 load_c_reg,
   output logic                 enable_c_reg,
   output logic                 load_temp_reg,
   output logic                 load_output_reg,
   output logic                 load_inst_reg,
   output logic                 enable_inst_reg,
   output logic                 clear_inst_reg,
   output logic [T_STATE_W-1:0] t_state,
   output logic                 halted
);
   state_e     state_q, state_d;
   logic [3:0] op;
   logic       advance, ring_zero, ring_restart, ring_step;
   logic       unused_ir;
   ctrl_t      c;
   assign op        = controller_sequencer_input[7:4];
   assign unused_ir = ^controller_sequencer_input[3:0];
   // A step advances only while the opcode still has a later step; anything
   // else (last step, or an impossible t_state) restarts at T0.
   always_comb begin
      advance      = t_state[T0] | t_state[T1] | (t_state[T2] & has_t3(op)) | (t_state[T3] & has_t4(op));
      state_d      = state_q == ST_INIT ? ST_RUN :
                     state_q == ST_RUN && enable_ring_counter && t_state[T2] && op == OP_HLT ? ST_HALT : state_q;
      ring_zero    = state_d != ST_RUN;
      ring_restart = state_q == ST_INIT || (enable_ring_counter && !advance);
      ring_step    = enable_ring_counter && advance;
   end
   always_ff @(posedge clk)
      state_q <= !clear ? ST_INIT : state_d;
   ring_counter u_ring (
      .clk     (clk),
      .clear   (clear),
      .zero    (ring_zero),
      .restart (ring_restart),
      .step    (ring_step),
      .t_state (t_state)
   );
   always_comb begin
      c = '0;
      if (state_q == ST_INIT) begin
         c.clear_pc       = 1'b1;
         c.clear_inst_reg = 1'b1;
      end else if (state_q == ST_RUN && enable_ring_counter) begin
         if (t_state[T0]) begin
            c.enable_pc = 1'b1;
            c.load_mar  = 1'b1;
         end
         if (t_state[T1]) begin
            c.ce_ram        = 1'b1;
            c.load_inst_reg = 1'b1;
            c.count_pc      = 1'b1;
         end
         if (t_state[T2])
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  c.enable_inst_reg = 1'b1;
                  c.load_mar        = 1'b1;
               end
               OP_LDI: begin
                  c.enable_inst_reg = 1'b1;
                  c.load_accum      = 1'b1;
               end
               OP_JMP: begin
                  c.enable_inst_reg = 1'b1;
                  c.load_pc         = 1'b1;
               end
               OP_JZ: begin
                  c.enable_inst_reg = zero_flag;
                  c.load_pc         = zero_flag;
               end
               OP_JC: begin
                  c.enable_inst_reg = carry_flag;
                  c.load_pc         = carry_flag;
               end
               OP_MVB: begin
                  c.enable_accum = 1'b1;
                  c.load_b_reg   = 1'b1;
               end
               OP_MVC: begin
                  c.enable_accum = 1'b1;
                  c.load_c_reg   = 1'b1;
               end
               OP_OUT: begin
                  c.enable_accum    = 1'b1;
                  c.load_output_reg = 1'b1;
               end
               default: ;
            endcase
         if (t_state[T3])
            case (op)
               OP_LDA: begin
                  c.ce_ram     = 1'b1;
                  c.load_accum = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  c.ce_ram        = 1'b1;
                  c.load_temp_reg = 1'b1;
               end
               OP_STA: begin
                  c.enable_accum = 1'b1;
                  c.ce_ram       = 1'b1;
                  c.we_ram       = 1'b1;
               end
               default: ;
            endcase
         if (t_state[T4] && has_t4(op)) begin
            c.enable_alu = 1'b1;
            c.load_accum = 1'b1;
            c.sub_mode   = op == OP_SUB;
         end
      end
   end
   assign {count_pc, clear_pc, enable_pc, load_pc, load_accum, enable_accum, load_mar, ce_ram,
           we_ram, sub_mode, enable_alu, load_mdr_reg, enable_mdr_reg, load_b_reg, enable_b_reg,
           load_c_reg, enable_c_reg, load_temp_reg, load_output_reg, load_inst_reg,
           enable_inst_reg, clear_inst_reg} = c;
   assign halted = state_q == ST_HALT;
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: randomized and directed checks against a step-table reference model.
module tb_controller_sequencer;
   logic       clk = 1'b0;
   logic       clear = 1'b0, en = 1'b1, zf = 1'b0, cf = 1'b0;
   logic [7:0] ir = 8'h00;
   logic count_pc, clear_pc, enable_pc, load_pc, load_accum, enable_accum, load_mar, ce_ram;
   logic we_ram, sub_mode, enable_alu, load_mdr_reg, enable_mdr_reg, load_b_reg, enable_b_reg;
   logic load_c_reg, enable_c_reg, load_temp_reg, load_output_reg, load_inst_reg;
   logic enable_inst_reg, clear_inst_reg, halted;
   logic [9:0]  t_state;
   logic [21:0] ctrl_v;
   int checks = 0, failures = 0, out_pulses = 0;
   localparam int B_CNT = 21, B_CLR_PC = 20, B_EN_PC = 19, B_LD_PC = 18, B_LD_ACC = 17,
                  B_EN_ACC = 16, B_LD_MAR = 15, B_CE = 14, B_WE = 13, B_SUB = 12, B_ALU = 11,
                  B_LD_B = 8, B_LD_C = 6, B_TEMP = 4, B_OUT = 3, B_LD_IR = 2, B_EN_IR = 1,
                  B_CLR_IR = 0;
   localparam int M_INIT = 0, M_RUN = 1, M_HALT = 2;
   int m_mode = M_INIT, m_k = 0;

   controller_sequencer dut (
      .clk(clk), .clear(clear), .enable_ring_counter(en), .controller_sequencer_input(ir),
      .zero_flag(zf), .carry_flag(cf), .count_pc(count_pc), .clear_pc(clear_pc),
      .enable_pc(enable_pc), .load_pc(load_pc), .load_accum(load_accum),
      .enable_accum(enable_accum), .load_mar(load_mar), .ce_ram(ce_ram), .we_ram(we_ram),
      .sub_mode(sub_mode), .enable_alu(enable_alu), .load_mdr_reg(load_mdr_reg),
      .enable_mdr_reg(enable_mdr_reg), .load_b_reg(load_b_reg), .enable_b_reg(enable_b_reg),
      .load_c_reg(load_c_reg), .enable_c_reg(enable_c_reg), .load_temp_reg(load_temp_reg),
      .load_output_reg(load_output_reg), .load_inst_reg(load_inst_reg),
      .enable_inst_reg(enable_inst_reg), .clear_inst_reg(clear_inst_reg),
      .t_state(t_state), .halted(halted)
   );

   always #5 clk = ~clk;

   assign ctrl_v = {count_pc, clear_pc, enable_pc, load_pc, load_accum, enable_accum, load_mar,
                    ce_ram, we_ram, sub_mode, enable_alu, load_mdr_reg, enable_mdr_reg,
                    load_b_reg, enable_b_reg, load_c_reg, enable_c_reg, load_temp_reg,
                    load_output_reg, load_inst_reg, enable_inst_reg, clear_inst_reg};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int nsteps(input logic [3:0] op);
      return (op == 4'h2 || op == 4'h3) ? 3 : (op == 4'h1 || op == 4'h4) ? 2 : 1;
   endfunction

   // Controls for fetch step k (0,1) or execute step k-2, straight from the opcode table.
   function automatic logic [21:0] step_ctrl(input int k, input logic [3:0] op, input logic z, input logic c);
      logic [21:0] v;
      int j;
      v = '0;
      j = k - 2;
      if (k == 0) begin v[B_EN_PC] = 1; v[B_LD_MAR] = 1; end
      else if (k == 1) begin v[B_CE] = 1; v[B_LD_IR] = 1; v[B_CNT] = 1; end
      else case (op)
         4'h1: if (j == 0) begin v[B_EN_IR] = 1; v[B_LD_MAR] = 1; end
               else if (j == 1) begin v[B_CE] = 1; v[B_LD_ACC] = 1; end
         4'h2, 4'h3: if (j == 0) begin v[B_EN_IR] = 1; v[B_LD_MAR] = 1; end
               else if (j == 1) begin v[B_CE] = 1; v[B_TEMP] = 1; end
               else if (j == 2) begin v[B_ALU] = 1; v[B_LD_ACC] = 1; v[B_SUB] = (op == 4'h3); end
         4'h4: if (j == 0) begin v[B_EN_IR] = 1; v[B_LD_MAR] = 1; end
               else if (j == 1) begin v[B_EN_ACC] = 1; v[B_CE] = 1; v[B_WE] = 1; end
         4'h5: if (j == 0) begin v[B_EN_IR] = 1; v[B_LD_ACC] = 1; end
         4'h6: if (j == 0) begin v[B_EN_IR] = 1; v[B_LD_PC] = 1; end
         4'h7: if (j == 0 && z) begin v[B_EN_IR] = 1; v[B_LD_PC] = 1; end
         4'h8: if (j == 0 && c) begin v[B_EN_IR] = 1; v[B_LD_PC] = 1; end
         4'h9: if (j == 0) begin v[B_EN_ACC] = 1; v[B_LD_B] = 1; end
         4'hA: if (j == 0) begin v[B_EN_ACC] = 1; v[B_LD_C] = 1; end
         4'hB: if (j == 0) begin v[B_EN_ACC] = 1; v[B_OUT] = 1; end
         default: ;
      endcase
      return v;
   endfunction

   task automatic model_step();
      if (!clear) begin m_mode = M_INIT; m_k = 0; end
      else if (m_mode == M_INIT) begin m_mode = M_RUN; m_k = 0; end
      else if (m_mode == M_RUN && en) begin
         if (m_k == 2 && ir[7:4] == 4'hF) begin m_mode = M_HALT; m_k = 0; end
         else if (m_k + 1 < 2 + nsteps(ir[7:4])) m_k++;
         else m_k = 0;
      end
   endtask

   task automatic tick();
      logic [21:0] exp_c;
      logic [9:0]  exp_t;
      int drivers;
      @(negedge clk);
      exp_c = '0;
      exp_t = '0;
      if (m_mode == M_INIT) begin exp_c[B_CLR_PC] = 1; exp_c[B_CLR_IR] = 1; end
      if (m_mode == M_RUN) begin
         exp_t = 10'(1) << m_k;
         if (en) exp_c = step_ctrl(m_k, ir[7:4], zf, cf);
      end
      check("ctrl", 32'(ctrl_v), 32'(exp_c));
      check("t_state", 32'(t_state), 32'(exp_t));
      check("halted", 32'(halted), 32'(m_mode == M_HALT));
      drivers = int'(enable_pc) + int'(enable_accum) + int'(enable_alu) + int'(enable_inst_reg)
              + int'(enable_b_reg) + int'(enable_c_reg) + int'(enable_mdr_reg) + int'(ce_ram && !we_ram);
      check("bus_excl", 32'(drivers <= 1), 32'd1);
      if (load_output_reg) out_pulses++;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic run_instr(input logic [7:0] instr, input logic z, input logic c);
      bit done;
      ir = instr;
      zf = z;
      cf = c;
      done = 0;
      for (int i = 0; i < 8 && !done; i++) begin
         tick();
         done = (m_mode != M_RUN || m_k == 0);
      end
      check("instr_done", 32'(done), 32'd1);
   endtask

   initial begin
      @(posedge clk);
      m_mode = M_INIT;
      #1;
      tick();
      clear = 1'b1;
      tick();
      check("t0_after_init", 32'(t_state), 32'h001);
      run_instr(8'h2E, 0, 0);
      run_instr(8'h75, 1, 0);
      run_instr(8'h75, 0, 0);
      ir = 8'h3A;
      for (int i = 0; i < 6 && m_k != 3; i++) tick();
      check("reach_sub_t3", 32'(m_k), 32'd3);
      en = 1'b0;
      repeat (5) tick();
      en = 1'b1;
      tick();
      tick();
      check("sub_back_t0", 32'(t_state), 32'h001);
      out_pulses = 0;
      run_instr(8'h57, 0, 0);
      run_instr(8'h90, 0, 0);
      run_instr(8'hB0, 0, 0);
      run_instr(8'hF0, 0, 0);
      check("halted_after_hlt", 32'(halted), 32'd1);
      repeat (20) tick();
      check("out_pulses", 32'(out_pulses), 32'd1);
      clear = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 7) != 0);
         clear = ($urandom_range(0, 39) != 0);
         zf = 1'($urandom_range(0, 1));
         cf = 1'($urandom_range(0, 1));
         if (m_mode == M_RUN && m_k == 0) ir = 8'($urandom);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
